// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: ID-stage forwarding, load-use and MDU scoreboard hazard unit with stall/flush counters
// Ports: id_* operand requests and register-file values; fwd_* per-stage producers (slice i = stage i,
// 0 youngest); is_jump flush request; mdu_* multi-cycle op tracking; final_rd1/2 forwarded operands;
// pipeline_stop/pipeline_flush pipeline control; mdu_busy scoreboard state; stall_cnt/flush_cnt saturating
// perf counters. rst_n is an asynchronous reset asserted high.
module hazard_unit_mc #(
    parameter int XLEN     = 32,
    parameter int REGW     = 5,
    parameter int NFWD     = 3,
    parameter int LOAD_RDY = 1,
    parameter int CNTW     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REGW-1:0]      id_rs1,
    input  logic [REGW-1:0]      id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [XLEN-1:0]      id_rd1,
    input  logic [XLEN-1:0]      id_rd2,
    input  logic [NFWD*REGW-1:0] fwd_wr,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_is_load,
    input  logic [NFWD*XLEN-1:0] fwd_wd,
    input  logic                 is_jump,
    input  logic                 mdu_start,
    input  logic [REGW-1:0]      mdu_rd,
    input  logic                 mdu_done,
    output logic [XLEN-1:0]      final_rd1,
    output logic [XLEN-1:0]      final_rd2,
    output logic                 pipeline_stop,
    output logic                 pipeline_flush,
    output logic                 mdu_busy,
    output logic [CNTW-1:0]      stall_cnt,
    output logic [CNTW-1:0]      flush_cnt
);
    logic            sb_valid;
    logic [REGW-1:0] sb_rd;
    logic            ld1, ld2, load_stall, mdu_stall;
    // Walk oldest to youngest so the youngest matching stage is the last writer and wins.
    always_comb begin
        final_rd1 = id_rd1;
        final_rd2 = id_rd2;
        ld1 = 1'b0;
        ld2 = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_wr[i*REGW +: REGW] == id_rs1 && id_rs1 != '0 && id_use_rs1) begin
                final_rd1 = fwd_wd[i*XLEN +: XLEN];
                ld1 = fwd_is_load[i] && (i < LOAD_RDY);
            end
            if (fwd_we[i] && fwd_wr[i*REGW +: REGW] == id_rs2 && id_rs2 != '0 && id_use_rs2) begin
                final_rd2 = fwd_wd[i*XLEN +: XLEN];
                ld2 = fwd_is_load[i] && (i < LOAD_RDY);
            end
        end
    end
    assign load_stall = ld1 || ld2;
    // A second MDU op cannot issue while the first is still outstanding, unless it completes now.
    assign mdu_stall = (sb_valid && ((id_use_rs1 && id_rs1 == sb_rd) || (id_use_rs2 && id_rs2 == sb_rd)))
                    || (mdu_start && sb_valid && !mdu_done);
    assign pipeline_flush = is_jump && !rst_n;
    assign pipeline_stop  = (load_stall || mdu_stall) && !is_jump && !rst_n;
    assign mdu_busy       = sb_valid;
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sb_valid  <= 1'b0;
            sb_rd     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mdu_start && !pipeline_stop && !pipeline_flush && mdu_rd != '0) begin
                sb_valid <= 1'b1;
                sb_rd    <= mdu_rd;
            end else if (mdu_done) begin
                sb_valid <= 1'b0;
            end
            if (pipeline_stop && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (pipeline_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed bench for hazard_unit_mc with a second 4-bit-counter instance for saturation
module tb_hazard_unit_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, mdu_rd;
    logic        id_use_rs1, id_use_rs2, is_jump, mdu_start, mdu_done;
    logic [31:0] id_rd1, id_rd2;
    logic [14:0] fwd_wr;
    logic [2:0]  fwd_we, fwd_is_load;
    logic [95:0] fwd_wd;
    logic [31:0] final_rd1, final_rd2, stall_cnt, flush_cnt;
    logic        pipeline_stop, pipeline_flush, mdu_busy;
    logic [31:0] b_rd1, b_rd2;
    logic        b_stop, b_flush, b_busy;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    int errs = 0, checks = 0, exp_stall = 0, exp_flush = 0;

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .fwd_wr(fwd_wr), .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .fwd_wd(fwd_wd),
        .is_jump(is_jump), .mdu_start(mdu_start), .mdu_rd(mdu_rd), .mdu_done(mdu_done),
        .final_rd1(final_rd1), .final_rd2(final_rd2), .pipeline_stop(pipeline_stop),
        .pipeline_flush(pipeline_flush), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit_mc #(.CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .fwd_wr(fwd_wr), .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .fwd_wd(fwd_wd),
        .is_jump(is_jump), .mdu_start(mdu_start), .mdu_rd(mdu_rd), .mdu_done(mdu_done),
        .final_rd1(b_rd1), .final_rd2(b_rd2), .pipeline_stop(b_stop),
        .pipeline_flush(b_flush), .mdu_busy(b_busy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd1 = '0; id_rd2 = '0; fwd_wr = '0; fwd_we = '0; fwd_is_load = '0; fwd_wd = '0;
        is_jump = 0; mdu_start = 0; mdu_rd = '0; mdu_done = 0;
    endtask

    task automatic stage(input int i, input logic [4:0] r, input logic ld, input logic [31:0] d);
        fwd_wr[i*5 +: 5] = r;
        fwd_we[i] = 1'b1;
        fwd_is_load[i] = ld;
        fwd_wd[i*32 +: 32] = d;
    endtask

    task automatic tick(input int s, input int f);
        exp_stall += s;
        exp_flush += f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        clr();
        #1 rst_n = 1;
        stage(0, 7, 1, 32'hDEAD0000); id_rs2 = 7; id_use_rs2 = 1;
        #1;
        chk("rst_stop", {31'b0, pipeline_stop}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_busy", {31'b0, mdu_busy}, 0);
        is_jump = 1;
        #1 chk("rst_flush", {31'b0, pipeline_flush}, 0);
        @(negedge clk);
        rst_n = 0;
        clr();
        #1;
        // forwarding priority
        stage(0, 5, 0, 32'hAAAA0000); stage(1, 6, 0, 32'h11111111); stage(2, 5, 0, 32'h55550000);
        id_rs1 = 5; id_use_rs1 = 1; id_rd1 = 32'h12345678;
        id_rs2 = 6; id_use_rs2 = 1; id_rd2 = 32'h87654321;
        #1;
        chk("fwd_prio", final_rd1, 32'hAAAA0000);
        chk("fwd_stage1", final_rd2, 32'h11111111);
        chk("fwd_stop", {31'b0, pipeline_stop}, 0);
        fwd_we[0] = 0;
        #1 chk("fwd_oldest", final_rd1, 32'h55550000);
        fwd_we = '0;
        #1 chk("fwd_pass", final_rd1, 32'h12345678);
        // x0 and use flags
        clr(); stage(0, 0, 0, 32'hCAFE0000); id_rs1 = 0; id_use_rs1 = 1; id_rd1 = 32'h42;
        #1 chk("x0_pass", final_rd1, 32'h42);
        clr(); stage(0, 5, 1, 32'hCAFE0001); id_rs2 = 5; id_use_rs2 = 0; id_rd2 = 32'h77;
        #1;
        chk("nouse_rd2", final_rd2, 32'h77);
        chk("nouse_stop", {31'b0, pipeline_stop}, 0);
        // load-use
        clr(); stage(0, 7, 1, 32'hDEAD0000); id_rs2 = 7; id_use_rs2 = 1; id_rd2 = 32'h22;
        #1 chk("lu_stop", {31'b0, pipeline_stop}, 1);
        tick(1, 0);
        clr(); stage(1, 7, 1, 32'hBEEF0001); id_rs2 = 7; id_use_rs2 = 1;
        #1;
        chk("lu_fwd", final_rd2, 32'hBEEF0001);
        chk("lu_stop2", {31'b0, pipeline_stop}, 0);
        chk("lu_stall_cnt", stall_cnt, exp_stall);
        // MDU scoreboard
        clr(); mdu_start = 1; mdu_rd = 9;
        #1 chk("mdu_start_stop", {31'b0, pipeline_stop}, 0);
        tick(0, 0);
        mdu_start = 0; id_rs1 = 9; id_use_rs1 = 1;
        #1 chk("mdu_busy", {31'b0, mdu_busy}, 1);
        for (int k = 0; k < 3; k++) begin
            chk("mdu_dep_stop", {31'b0, pipeline_stop}, 1);
            tick(1, 0);
        end
        mdu_done = 1;
        #1 chk("mdu_done_stop", {31'b0, pipeline_stop}, 1);
        tick(1, 0);
        mdu_done = 0;
        #1;
        chk("mdu_after_busy", {31'b0, mdu_busy}, 0);
        chk("mdu_after_stop", {31'b0, pipeline_stop}, 0);
        clr(); mdu_start = 1; mdu_rd = 9;
        tick(0, 0);
        mdu_rd = 10;
        #1 chk("mdu_struct", {31'b0, pipeline_stop}, 1);
        tick(1, 0);
        mdu_start = 0; id_rs1 = 10; id_use_rs1 = 1;
        #1 chk("mdu_rd_kept", {31'b0, pipeline_stop}, 0);
        id_rs1 = 9;
        #1 chk("mdu_rd9", {31'b0, pipeline_stop}, 1);
        id_use_rs1 = 0; mdu_start = 1; mdu_rd = 10; mdu_done = 1;
        #1 chk("sd_stop", {31'b0, pipeline_stop}, 0);
        tick(0, 0);
        clr(); id_rs1 = 10; id_use_rs1 = 1;
        #1;
        chk("sd_busy", {31'b0, mdu_busy}, 1);
        chk("sd_stop_new", {31'b0, pipeline_stop}, 1);
        id_rs1 = 9;
        #1 chk("sd_stop_old", {31'b0, pipeline_stop}, 0);
        mdu_done = 1;
        tick(0, 0);
        clr();
        #1 chk("sd_cleared", {31'b0, mdu_busy}, 0);
        mdu_start = 1; mdu_rd = 0;
        tick(0, 0);
        clr();
        #1 chk("rd0_busy", {31'b0, mdu_busy}, 0);
        // flush over stall
        stage(0, 7, 1, 32'hDEAD0002); id_rs2 = 7; id_use_rs2 = 1; is_jump = 1;
        #1;
        chk("fl_flush", {31'b0, pipeline_flush}, 1);
        chk("fl_stop", {31'b0, pipeline_stop}, 0);
        tick(0, 1);
        chk("fl_flush_cnt", flush_cnt, exp_flush);
        chk("fl_stall_cnt", stall_cnt, exp_stall);
        // asynchronous reset mid-MDU
        clr(); mdu_start = 1; mdu_rd = 9;
        tick(0, 0);
        clr();
        #1 chk("rm_busy_pre", {31'b0, mdu_busy}, 1);
        rst_n = 1;
        #1;
        chk("rm_busy", {31'b0, mdu_busy}, 0);
        chk("rm_stall_cnt", stall_cnt, 0);
        chk("rm_flush_cnt", flush_cnt, 0);
        #1 rst_n = 0;
        exp_stall = 0;
        exp_flush = 0;
        mdu_done = 1;
        tick(0, 0);
        clr(); id_rs1 = 9; id_use_rs1 = 1;
        #1;
        chk("rm_done_busy", {31'b0, mdu_busy}, 0);
        chk("rm_done_stop", {31'b0, pipeline_stop}, 0);
        // saturation
        clr(); stage(0, 7, 1, 32'hDEAD0003); id_rs2 = 7; id_use_rs2 = 1;
        for (int k = 0; k < 20; k++) tick(1, 0);
        chk("sat4", {28'b0, b_stall_cnt}, 15);
        chk("sat32", stall_cnt, exp_stall);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard/forwarding unit for the ID stage.
- Generalises the fixed EX/MEM/WB forwarding to NFWD producer stages.
- Adds explicit rs1/rs2 use flags, configurable load-data-ready stage, and a one-deep scoreboard for a multi-cycle MDU (mul/div).
- Adds saturating stall/flush performance counters.
- Sits beside the decoder; drives stall/flush to the IF/ID and ID/EX registers and supplies forwarded operands to ID.

Parameters:
- XLEN, 32, data width.
- REGW, 5, register index width.
- NFWD, 3, number of forwarding producer stages; index 0 = youngest (EX), NFWD-1 = oldest (WB).
- LOAD_RDY, 1, lowest stage index at which load data is valid in fwd_wd; a load in stage index < LOAD_RDY causes a stall.
- CNTW, 32, perf counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-high (asserted = 1)
- id_rs1  in  REGW  ID source register 1
- id_rs2  in  REGW  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2 (ALU-B = RS2, store data, branch)
- id_rd1  in  XLEN  register-file value for rs1
- id_rd2  in  XLEN  register-file value for rs2
- fwd_wr  in  NFWD*REGW  destination register per stage, slice i = stage i
- fwd_we  in  NFWD  register write enable per stage
- fwd_is_load  in  NFWD  stage i holds a load
- fwd_wd  in  NFWD*XLEN  write-back data per stage
- is_jump  in  1  taken branch/jump resolved this cycle
- mdu_start  in  1  MDU op leaves ID this cycle (accepted only when not stalled)
- mdu_rd  in  REGW  MDU destination
- mdu_done  in  1  MDU result written this cycle
- final_rd1  out  XLEN  forwarded rs1 operand
- final_rd2  out  XLEN  forwarded rs2 operand
- pipeline_stop  out  1  hold PC and IF/ID, bubble into ID/EX
- pipeline_flush  out  1  clear IF/ID and ID/EX
- mdu_busy  out  1  scoreboard entry valid
- stall_cnt  out  CNTW  cycles with pipeline_stop=1
- flush_cnt  out  CNTW  cycles with pipeline_flush=1

Behaviour:
- Match, per operand r and stage i: fwd_we[i] && fwd_wr[i]==id_rsr && id_rsr!=0 && id_use_rsr.
- Forwarding priority: lowest matching index wins. No match -> id_rd1/id_rd2 passes through. Fully combinational, zero latency.
- Load hazard: a winning match at stage i < LOAD_RDY with fwd_is_load[i]=1 raises load_stall. The operand value is don't-care while stalled.
- Scoreboard state: sb_valid and sb_rd.
  - Set on mdu_start && !pipeline_stop && !pipeline_flush, with sb_rd=mdu_rd.
  - Cleared on mdu_done.
  - If start and done occur in the same cycle, the new op wins (valid stays 1, sb_rd updates).
  - mdu_rd=0 does not set valid.
- mdu_stall when sb_valid && ((id_use_rs1 && id_rs1==sb_rd) || (id_use_rs2 && id_rs2==sb_rd)), or when mdu_start is requested while sb_valid && !mdu_done (structural hazard).
- pipeline_flush = is_jump.
- pipeline_stop = (load_stall || mdu_stall) && !is_jump. Flush overrides stall.
- mdu_busy = sb_valid.
- Counters:
  - stall_cnt increments on each cycle with pipeline_stop=1.
  - flush_cnt increments on each cycle with pipeline_flush=1.
  - Both saturate at all-ones; no wrap.
- Reset (rst_n=1, asynchronous): sb_valid=0, sb_rd=0, both counters=0.
  - pipeline_stop and pipeline_flush are forced 0 while reset is asserted.
  - final_rd1/2 remain combinational passthrough/forward.
- Reset mid-MDU op: the scoreboard clears and a later mdu_done is ignored (done with sb_valid=0 is a no-op).

Test Plan:
- Forwarding priority: stages 0 and 2 both write x5 (0xAAAA0000, 0x55550000), id_rs1=5, use_rs1=1 -> final_rd1=0xAAAA0000, stop=0.
- x0 and use flags: fwd_wr[0]=0 with we=1 and rs1=0 -> final_rd1=id_rd1. rs2 match but id_use_rs2=0 -> final_rd2=id_rd2, no stall.
- Load-use: stage 0 load to x7, id_rs2=7, use_rs2=1, LOAD_RDY=1 -> stop=1 for 1 cycle. Next cycle the load is in stage 1 -> final_rd2=fwd_wd[1], stop=0, stall_cnt=1.
- MDU scoreboard: mdu_start with rd=9, then id_rs1=9 -> stop=1 every cycle until mdu_done. The cycle after done, stop=0 and mdu_busy=0. A second mdu_start while busy -> stop=1.
- Flush over stall: load hazard together with is_jump=1 -> flush=1, stop=0, flush_cnt+1, stall_cnt unchanged.
- Reset/saturation: assert rst_n mid-MDU -> busy=0 and counters 0 immediately (asynchronous). Preload CNTW=4 build, run 20 stall cycles -> stall_cnt=15.
